pc_fetch_unit: RTL

//  PC register, next-PC mux and instruction fetch stage directly upstream of the single-cycle controller.

---
 rtl/pc_fetch_unit_if.sv | 12 +
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory req/ack port between fetch unit and memory
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, next-PC mux and req/ack instruction fetch; FETCH_TIMEOUT_EN adds an ack timeout
module pc_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enPC,
  input  logic              PCsel1,
  input  logic              PCsel0,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   alu_result,
  pc_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [2:0]        lorbtype,
  output logic [3:0]        alu_action,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              instr_valid,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t          state;
  logic            req_q;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    next_pc = RESET_PC;
    case ({PCsel1, PCsel0})
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc + imm;
      2'b10:   next_pc = alu_result & ~XLEN'(1);
      default: next_pc = RESET_PC;
    endcase
  end

  assign misaligned = |next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      fetch_err   <= 1'b0;
      state       <= IDLE;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else if (enPC) begin
      // A new PC always wins, even over an ack arriving in the same cycle.
      pc          <= next_pc;
      instr       <= '0;
      instr_valid <= 1'b0;
      if (misaligned || fetch_err) begin
        if (misaligned) fetch_err <= 1'b1;
        state <= IDLE;
        req_q <= 1'b0;
      end else begin
        state <= FETCH;
        req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            fetch_err <= 1'b1;
            req_q     <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  assign opcode     = instr[6:0];
  assign lorbtype   = instr[14:12];
  assign alu_action = {instr[30], instr[14:12]};
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign rd         = instr[11:7];

endmodule
